// File: rtl/store_buffer.sv
// Store buffer between the CPU and the data cache. Stores are queued in a
// small circular FIFO and drained to memory in the background; loads hit the
// youngest matching buffered store or stall for a memory read that bypasses
// the queued stores.
//
// Handshake: a CPU request (CPU_WRITE / CPU_READ) is held until a rising CLK
// edge where CPU_BUSYWAIT is low, and it is accepted on that edge. A memory
// request (MEM_WRITE / MEM_READ) completes on the rising edge where it is
// asserted while MEM_BUSYWAIT is low.
module store_buffer #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CPU_WRITE,
  input  logic          CPU_READ,
  input  logic [7:0]    CPU_ADDRESS,
  input  logic [7:0]    CPU_WRITEDATA,
  output logic [7:0]    CPU_READDATA,
  output logic          CPU_BUSYWAIT,
  output logic          MEM_WRITE,
  output logic          MEM_READ,
  output logic [7:0]    MEM_ADDRESS,
  output logic [7:0]    MEM_WRITEDATA,
  input  logic [7:0]    MEM_READDATA,
  input  logic          MEM_BUSYWAIT,
  output logic [1:0]    DBG_STATE,
  output logic [CW-1:0] DBG_COUNT
);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    addr_q [DEPTH];
  logic [7:0]    addr_d [DEPTH];
  logic [7:0]    data_q [DEPTH];
  logic [7:0]    data_d [DEPTH];

  logic          full;
  logic          enq;
  logic          deq;
  logic          mem_done;
  logic          fwd_hit;
  logic [7:0]    fwd_data;
  logic          rd_miss;
  logic [PW-1:0] idx;

  assign full      = (count_q == CW'(DEPTH));
  assign enq       = CPU_WRITE && !full;
  assign mem_done  = !MEM_BUSYWAIT;
  assign rd_miss   = CPU_READ && !fwd_hit;
  assign DBG_STATE = state_q;
  assign DBG_COUNT = count_q;

  // Forwarding search: walk valid entries oldest to youngest so the last
  // match (the youngest store to that address) wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = 8'h00;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == CPU_ADDRESS)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // Controller: memory request generation, CPU stall/read data, next state.
  always_comb begin
    state_d       = state_q;
    deq           = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_READ      = 1'b0;
    MEM_ADDRESS   = 8'h00;
    MEM_WRITEDATA = 8'h00;
    CPU_READDATA  = 8'h00;
    // Store stall uses the pre-edge count: a dequeue on this edge does not help.
    CPU_BUSYWAIT  = (CPU_WRITE && full) || rd_miss;
    if (CPU_READ && fwd_hit) begin
      CPU_READDATA = fwd_data;
    end
    unique case (state_q)
      IDLE: begin
        if (rd_miss) begin
          state_d = LOAD;
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = addr_q[head_q];
        MEM_WRITEDATA = data_q[head_q];
        // The in-flight write always finishes before a pending load starts.
        if (mem_done) begin
          deq = 1'b1;
          if (rd_miss) begin
            state_d = LOAD;
          end else if (count_q - CW'(1) + CW'(enq) != '0) begin
            state_d = DRAIN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      LOAD: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = CPU_ADDRESS;
        if (mem_done) begin
          CPU_READDATA = MEM_READDATA;
          CPU_BUSYWAIT = CPU_WRITE && full;
          state_d      = (count_q != '0) ? DRAIN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO pointer, count and entry updates.
  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(enq);
    count_d = count_q + CW'(enq) - CW'(deq);
    addr_d  = addr_q;
    data_d  = data_q;
    if (enq) begin
      addr_d[tail_q] = CPU_ADDRESS;
      data_d[tail_q] = CPU_WRITEDATA;
    end
  end

  // Control registers with synchronous reset; reset discards all entries.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, 4, number of buffered store entries (power of two, 2..8).
REQ-002 Clocking SHALL be: reset RESET, synchronous, active-high; clock CLK.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RESET  input  1  synchronous active-high reset, sampled on rising CLK.
REQ-005 CPU_WRITE  input  1  CPU store request (sw/swi), held until CPU_BUSYWAIT low at a rising edge.
REQ-006 CPU_READ  input  1  CPU load request (lw/lwi), held until CPU_BUSYWAIT low at a rising edge.
REQ-007 CPU_ADDRESS  input  8  byte address (ALU result).
REQ-008 CPU_WRITEDATA  input  8  store data (register operand 1).
REQ-009 CPU_READDATA  output  8  load data to the register-file write mux.
REQ-010 CPU_BUSYWAIT  output  1  CPU stall request.
REQ-011 MEM_WRITE / MEM_READ  output  1 each  request to data cache.
REQ-012 MEM_ADDRESS / MEM_WRITEDATA  output  8 each  data-cache address and store data.
REQ-013 MEM_READDATA  input  8  data-cache load data.
REQ-014 MEM_BUSYWAIT  input  1  data-cache stall; a request completes on the rising edge where it is asserted and MEM_BUSYWAIT=0.

Function
REQ-015 Storage SHALL be a circular FIFO of DEPTH {address, data} entries with head pointer, tail pointer and a count of width log2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-016 Enqueue: on a rising edge with CPU_WRITE=1 and count<DEPTH (count sampled before the edge), write {CPU_ADDRESS, CPU_WRITEDATA} at tail and increment tail.
REQ-017 Store stall: CPU_BUSYWAIT=1 while CPU_WRITE=1 and count==DEPTH; a same-cycle dequeue does not free the slot for the current edge.
REQ-018 Forwarding: on CPU_READ=1, if any valid entry matches CPU_ADDRESS, CPU_READDATA is the youngest matching entry's data combinationally; CPU_BUSYWAIT=0; no memory read is issued.
REQ-019 Read miss: CPU_READ=1 with no match stalls the CPU (CPU_BUSYWAIT=1) until the cycle the memory read completes; in that cycle CPU_BUSYWAIT=0 and CPU_READDATA=MEM_READDATA.
REQ-020 FSM states IDLE, DRAIN, LOAD; register reset state IDLE.
REQ-021 IDLE: read miss pending -> LOAD; else count>0 -> DRAIN; else stay IDLE.
REQ-022 DRAIN: MEM_WRITE=1, MEM_ADDRESS/MEM_WRITEDATA = head entry. On completion, increment head, decrement count, then go to LOAD if a read miss is pending, else DRAIN if count after dequeue >0, else IDLE.
REQ-023 LOAD: MEM_READ=1, MEM_ADDRESS=CPU_ADDRESS. On completion -> DRAIN if count>0, else IDLE.
REQ-024 An in-flight write is never aborted: a read miss arriving during DRAIN waits for that write's completion.
REQ-025 A read miss takes priority over further drains (loads bypass non-matching older stores).
REQ-026 Simultaneous enqueue and dequeue on one edge leaves count unchanged and advances both pointers.
REQ-027 Outside the active state, MEM_WRITE=0 and MEM_READ=0; MEM_ADDRESS/MEM_WRITEDATA are don't-care.
REQ-028 CPU_READ and CPU_WRITE asserted together is illegal; behaviour is unspecified.

Reset
REQ-029 On a rising edge with RESET=1: state=IDLE, head=tail=count=0; buffered entries are discarded, including any in-flight write or read.
REQ-030 The first cycle after reset: MEM_WRITE=0, MEM_READ=0, CPU_BUSYWAIT=0 (given no CPU request), CPU_READDATA=0 when there is no read.

Verification
REQ-031 Four stores to 0x10..0x13 with data 0xA0..0xA3 and MEM_BUSYWAIT held high -> no CPU stall; the fifth store stalls; releasing MEM_BUSYWAIT drains 0x10/0xA0 first, and the fifth store enqueues on the following edge.
REQ-032 Store 0x20<-0x55, then 0x20<-0x66, then load 0x20 while MEM_BUSYWAIT=1 -> CPU_READDATA=0x66 with CPU_BUSYWAIT=0 and MEM_READ never asserted.
REQ-033 Two stores buffered, load of 0x30 (miss) during the first drain -> the first write completes, then MEM_READ at 0x30; returned 0x7E reaches CPU_READDATA; the second store drains afterwards.
REQ-034 Eight stores with single-cycle memory -> pointers wrap; the MEM_WRITE order equals the issue order; count returns to 0 and state to IDLE.
REQ-035 RESET asserted mid-DRAIN with three entries -> next cycle MEM_WRITE=0, count=0, and no buffered write is ever issued.
REQ-036 Store and completing dequeue on the same edge with count=2 -> count stays 2 and the new entry drains in FIFO order.
